// File: rtl/module_spi_master_multi.sv
// module_spi_master_multi: bus-mapped SPI master with a word buffer and multi-word burst engine.
// Define SPI_LOOPBACK_EN to make ctrl[8] writable and route mosi back into the receive path.
module module_spi_master_multi #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16,
    parameter int N_CS    = 4,
    parameter int CLK_DIV = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     we_i,
    input  logic                     reg_sel_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [31:0]              data_i,
    output logic [31:0]              data_o,
    input  logic                     miso_i,
    output logic                     mosi_o,
    output logic                     sck_o,
    output logic [N_CS-1:0]          cs_o,
    output logic                     busy_o,
    output logic                     done_o
);
`ifdef SPI_LOOPBACK_EN
    localparam bit LB_EN = 1'b1;
`else
    localparam bit LB_EN = 1'b0;
`endif
    localparam int AW = $clog2(DEPTH);
    localparam int HW = $clog2(2 * DATA_W);
    localparam int CW = $clog2(CLK_DIV + 1);

    typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, NEXT, CS_HOLD} state_t;
    state_t state, state_n;

    logic              send, all_ones, cpha, cpol, lb;
    logic [3:0]        cs_sel;
    logic [7:0]        n_end, n_rx;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] sr, rx, word;
    logic [AW-1:0]     idx, idx_n;
    logic [HW-1:0]     hc;
    logic [CW-1:0]     cnt;
    logic              fin, tick, last_half, more, samp, cs_ok;
    logic [31:0]       ctrl;
    logic              unused;

    assign unused = ^{data_i[31:24], data_i[15:9]};

    always_comb begin
        tick      = cnt == CW'(CLK_DIV - 1);
        last_half = hc == HW'(2 * DATA_W - 1);
        more      = idx != n_end[AW-1:0];
        idx_n     = idx + 1'b1;
        cs_ok     = 32'(cs_sel) < N_CS;
        // the next word is fetched one slot ahead while NEXT retires the current one
        word      = all_ones ? '1 : mem[state == IDLE ? '0 : idx_n];
        samp      = (LB_EN && lb) ? mosi_o : miso_i;
        ctrl      = {n_rx, n_end, 7'd0, lb, cs_sel, cpol, cpha, all_ones, send};
        busy_o    = send || state != IDLE;
        cs_o      = (state != IDLE) ? ~(N_CS'(1) << cs_sel) : '1;
        data_o    = reg_sel_i ? 32'(mem[addr_i]) : ctrl;
        state_n   = state;
        unique case (state)
            IDLE:     state_n = (send && cs_ok) ? CS_SETUP : IDLE;
            CS_SETUP: state_n = tick ? SHIFT : CS_SETUP;
            SHIFT:    state_n = (tick && last_half) ? NEXT : SHIFT;
            NEXT:     state_n = more ? SHIFT : CS_HOLD;
            CS_HOLD:  state_n = tick ? IDLE : CS_HOLD;
            default:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            {send, all_ones, cpha, cpol, lb, cs_sel, n_end, n_rx} <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            {sr, rx, idx, hc, cnt} <= '0;
            {sck_o, mosi_o, fin, done_o} <= '0;
        end else begin
            fin    <= 1'b0;
            done_o <= fin;
            cnt    <= (state == IDLE || state == NEXT || tick) ? '0 : cnt + 1'b1;
            unique case (state)
                IDLE: begin
                    sck_o <= cpol;
                    if (send) begin
                        {n_rx, idx, hc, rx} <= '0;
                        if (cs_ok) begin
                            mosi_o <= cpha ? 1'b0 : word[DATA_W-1];
                            sr     <= cpha ? word : word << 1;
                        end else begin
                            send <= 1'b0;
                            fin  <= 1'b1;
                        end
                    end else if (we_i && !reg_sel_i) begin
                        {n_end, lb, cs_sel, cpol, cpha, all_ones, send} <=
                            {data_i[23:16], data_i[8] & LB_EN, data_i[7:0]};
                    end else if (we_i) begin
                        mem[addr_i] <= data_i[DATA_W-1:0];
                    end
                end
                SHIFT: if (tick) begin
                    sck_o <= ~sck_o;
                    hc    <= last_half ? '0 : hc + 1'b1;
                    // even half-period ends on the leading edge; CPHA picks which edge samples
                    if (hc[0] == cpha) rx <= (rx << 1) | DATA_W'(samp);
                    else begin
                        mosi_o <= sr[DATA_W-1];
                        sr     <= sr << 1;
                    end
                end
                NEXT: begin
                    mem[idx] <= rx;
                    n_rx     <= n_rx + 1'b1;
                    idx      <= idx_n;
                    mosi_o   <= cpha ? 1'b0 : word[DATA_W-1];
                    sr       <= cpha ? word : word << 1;
                end
                CS_HOLD: if (tick) begin
                    send <= 1'b0;
                    fin  <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_module_spi_master_multi.sv
// tb_module_spi_master_multi: directed bench with an SPI slave model and a done-driven scoreboard.
module tb_module_spi_master_multi;
    localparam int DW = 8, DEPTH = 16, NCS = 4, CD = 4;

    logic        clk = 1'b0, rst = 1'b1, we = 1'b0, reg_sel = 1'b0, miso = 1'b0;
    logic [3:0]  addr = '0;
    logic [31:0] wdata = '0, rdata;
    logic        mosi, sck, busy, done;
    logic [3:0]  cs;

    always #5 clk = ~clk;

    module_spi_master_multi #(.DATA_W(DW), .DEPTH(DEPTH), .N_CS(NCS), .CLK_DIV(CD)) dut (
        .clk_i(clk), .rst_i(rst), .we_i(we), .reg_sel_i(reg_sel), .addr_i(addr),
        .data_i(wdata), .data_o(rdata), .miso_i(miso), .mosi_o(mosi), .sck_o(sck),
        .cs_o(cs), .busy_o(busy), .done_o(done)
    );

    typedef struct {
        int         start;
        int         lat;
        logic [7:0] mosi;
        logic [3:0] csm;
        int         falls;
    } exp_t;

    exp_t       q[$];
    exp_t       me;
    int         errors = 0, checks = 0, cyc = 0, bc = 0, falls = 0;
    logic       cpol_t = 1'b0, cpha_t = 1'b0, cs_p = 1'b0, sck_p = 1'b0;
    logic [7:0] s = '0, mcap = '0;
    logic [3:0] csm = '0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // slave replying 0x3C per word, cs/sck trackers and the done scoreboard
    always @(negedge clk) begin
        if (rst) begin
            {mcap, csm, s} = '0;
            {falls, bc} = '0;
            cs_p  = 1'b0;
            sck_p = sck;
        end else begin
            if (!(&cs) && !cs_p) begin
                falls++;
                s  = 8'h3C;
                bc = 0;
                if (!cpha_t) miso = s[7];
            end
            csm |= ~cs;
            if (!(&cs) && sck != sck_p) begin
                if ((sck != cpol_t) != cpha_t) mcap = {mcap[6:0], mosi};
                else if (!cpha_t) begin
                    s = s << 1;
                    bc++;
                    if (bc == 8) begin bc = 0; s = 8'h3C; end
                    miso = s[7];
                end else begin
                    miso = s[7];
                    s = s << 1;
                    bc++;
                    if (bc == 8) begin bc = 0; s = 8'h3C; end
                end
            end
            sck_p = sck;
            cs_p  = !(&cs);
            if (done) begin
                if (q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
                else begin
                    me = q.pop_front();
                    chk("latency", cyc - me.start, me.lat);
                    chk("mosi_word", mcap, me.mosi);
                    chk("cs_mask", csm, me.csm);
                    chk("cs_falls", falls, me.falls);
                end
                mcap  = '0;
                csm   = '0;
                falls = 0;
            end
        end
    end

    task automatic wr(input logic sel, input logic [3:0] a, input logic [31:0] d);
        reg_sel = sel; addr = a; wdata = d; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic sel, input logic [3:0] a, input logic [31:0] exp);
        reg_sel = sel; addr = a;
        #1 chk(name, rdata, exp);
    endtask

    task automatic start(input logic [31:0] c, input int lat, input logic [7:0] m, input logic [3:0] cm, input int f);
        exp_t e;
        e.start = cyc + 1; e.lat = lat; e.mosi = m; e.csm = cm; e.falls = f;
        q.push_back(e);
        wr(1'b0, 4'd0, c);
    endtask

    task automatic wait_idle(input int bound);
        for (int i = 0; i < bound && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            chk("done_timeout", q.size(), 32'd0);
            q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_cs", cs, 4'hF);
        chk("rst_sck", sck, 1'b0);
        chk("rst_mosi", mosi, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        rd_chk("rst_ctrl", 1'b0, 4'd0, 32'h0);
        rd_chk("rst_buf5", 1'b1, 4'd5, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        wr(1'b1, 4'd0, 32'hA5);
        start(32'h1, 75, 8'hA5, 4'b0001, 1);
        chk("busy_after_send", busy, 1'b1);
        wait_idle(200);
        chk("m0_sck_idle", sck, 1'b0);
        rd_chk("m0_buf0", 1'b1, 4'd0, 32'h3C);
        rd_chk("m0_ctrl", 1'b0, 4'd0, 32'h0100_0000);

        for (int m = 1; m < 4; m++) begin
            cpol_t = m[1];
            cpha_t = m[0];
            wr(1'b1, 4'd0, 32'hA5);
            wr(1'b0, 4'd0, 32'((m << 4) | (m << 2)));
            @(negedge clk);
            chk("mode_sck_preidle", sck, cpol_t);
            start(32'((m << 4) | (m << 2) | 1), 75, 8'hA5, 4'(1 << m), 1);
            wait_idle(200);
            chk("mode_sck_idle", sck, cpol_t);
            rd_chk("mode_buf0", 1'b1, 4'd0, 32'h3C);
        end

        cpol_t = 1'b0;
        cpha_t = 1'b0;
        wr(1'b0, 4'd0, 32'h0);
        @(negedge clk);
        start(32'h000F_0003, 1050, 8'hFF, 4'b0001, 1);
        wait_idle(1200);
        rd_chk("burst_ctrl", 1'b0, 4'd0, 32'h100F_0002);
        rd_chk("burst_buf15", 1'b1, 4'd15, 32'h3C);
        rd_chk("burst_buf7", 1'b1, 4'd7, 32'h3C);

        start(32'h1, 75, 8'h3C, 4'b0001, 1);
        repeat (10) @(negedge clk);
        chk("busy_mid", busy, 1'b1);
        wr(1'b0, 4'd0, 32'h0000_00F0);
        wr(1'b1, 4'd3, 32'h55);
        wait_idle(200);
        rd_chk("drop_ctrl", 1'b0, 4'd0, 32'h0100_0000);
        rd_chk("drop_buf3", 1'b1, 4'd3, 32'h3C);

        start(32'h51, 2, 8'h00, 4'b0000, 0);
        wait_idle(20);
        rd_chk("badcs_ctrl", 1'b0, 4'd0, 32'h0000_0050);
        chk("badcs_cs", cs, 4'hF);

        wr(1'b0, 4'd0, 32'h0);
`ifdef SPI_LOOPBACK_EN
        wr(1'b1, 4'd0, 32'h96);
        start(32'h101, 75, 8'h96, 4'b0001, 1);
        wait_idle(200);
        rd_chk("lb_buf0", 1'b1, 4'd0, 32'h96);
        rd_chk("lb_ctrl", 1'b0, 4'd0, 32'h0100_0100);
`else
        wr(1'b0, 4'd0, 32'h100);
        rd_chk("lb_off_ctrl", 1'b0, 4'd0, 32'h0);
`endif

        wr(1'b0, 4'd0, 32'h1);
        repeat (20) @(negedge clk);
        chk("pre_abort_cs", cs, 4'hE);
        rst = 1'b1;
        #1;
        chk("abort_cs", cs, 4'hF);
        chk("abort_sck", sck, 1'b0);
        chk("abort_busy", busy, 1'b0);
        rd_chk("abort_ctrl", 1'b0, 4'd0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        rd_chk("abort_buf0", 1'b1, 4'd0, 32'h0);
        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
